// File: rtl/freq_cntr_pkg.sv
// Shared types and default constants for the frequency counter datapath.
// Holds the period-meter FSM encoding and the period word shared with the divider.
// Pure declarations; no logic, no latency, no flow control.
package freq_cntr_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        COUNT     = 2'd2,
        DONE      = 2'd3
    } prd_state_t;

    localparam int CLKS_PER_TICK_DEF = 100;        // 100 MHz clk -> 1 us tick
    localparam int PRD_W_DEF         = 20;         // up to 1_048_575 us
    localparam int TIMEOUT_TICKS_DEF = 2_000_000;  // 2 s without a first edge

    typedef logic [PRD_W_DEF-1:0] prd_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_rise_edge.sv
// Brings an asynchronous level into clk and flags its rising edges.
// rise_tick is high for one cycle, 2-3 clk after the input rises.
// No backpressure: free-running, falling edges are ignored.
module sync_rise_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic rise_tick
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Shift chain: two metastability stages, then one history stage for edge detect.
    always_comb begin
        s1_d = d_async;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise_tick = s2_q & ~s3_q;

endmodule

// File: rtl/period_meter.sv
// Measures one full period of the async input sig in units of CLKS_PER_TICK clocks.
// done_tick fires the cycle after the terminating edge is seen; result held until next start.
// start is taken only while ready=1; there is no abort other than rst_n.
module period_meter
    import freq_cntr_pkg::*;
#(
    parameter int CLKS_PER_TICK = CLKS_PER_TICK_DEF,
    parameter int PRD_W         = PRD_W_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sig,
    output logic             ready,
    output logic             done_tick,
    output logic [PRD_W-1:0] prd,
    output logic             ovf
);

    // The period counter doubles as the first-edge timeout counter, so it must
    // hold whichever is larger: the saturated period or the timeout limit.
    localparam int TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int CNT_W  = max_int(PRD_W, $clog2(TIMEOUT_TICKS + 1));

    localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(CLKS_PER_TICK - 1);
    localparam logic [CNT_W-1:0]  PRD_MAX      = CNT_W'((longint'(1) << PRD_W) - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    logic sig_rise;

    sync_rise_edge u_sig_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_async   (sig),
        .rise_tick (sig_rise)
    );

    prd_state_t        state_q,  state_d;
    logic [TICK_W-1:0] tick_q,   tick_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [PRD_W-1:0]  prd_q,    prd_d;
    logic              ovf_q,    ovf_d;
    logic              ready_q,  ready_d;
    logic              done_q,   done_d;
    logic              wrap;

    assign wrap = (tick_q == TICK_LAST);

    // Next-state and datapath: tick prescaler feeding the period counter.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        period_d = period_q;
        prd_d    = prd_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = WAIT_EDGE;
                    tick_d   = '0;
                    period_d = '0;
                    prd_d    = '0;
                    ovf_d    = 1'b0;
                end
            end

            WAIT_EDGE: begin
                if (sig_rise) begin
                    // First edge: the period starts here, so restart both counters.
                    state_d  = COUNT;
                    tick_d   = '0;
                    period_d = '0;
                end else if (wrap) begin
                    tick_d = '0;
                    if (period_q == TIMEOUT_LAST) begin
                        state_d = DONE;
                        prd_d   = '0;
                        ovf_d   = 1'b1;
                    end else begin
                        period_d = period_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            COUNT: begin
                if (wrap && (period_q == PRD_MAX)) begin
                    // One more tick would not fit: saturate rather than wrap.
                    state_d = DONE;
                    tick_d  = '0;
                    prd_d   = '1;
                    ovf_d   = 1'b1;
                end else if (sig_rise) begin
                    // A tick completing on the edge cycle belongs to this period.
                    state_d = DONE;
                    tick_d  = '0;
                    prd_d   = PRD_W'(period_q + CNT_W'(wrap));
                    ovf_d   = 1'b0;
                end else if (wrap) begin
                    tick_d   = '0;
                    period_d = period_q + 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            period_q <= '0;
            prd_q    <= '0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            period_q <= period_d;
            prd_q    <= prd_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign ready     = ready_q;
    assign done_tick = done_q;
    assign prd       = prd_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
`timescale 1ns/1ps
module tb_period_meter;

    // Scaled-down build: 4 clocks per tick, 8-bit period, 300-tick timeout.
    localparam int C  = 4;
    localparam int PW = 8;
    localparam int TO = 300;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          sig;
    logic          ready;
    logic          done_tick;
    logic [PW-1:0] prd;
    logic          ovf;

    period_meter #(
        .CLKS_PER_TICK (C),
        .PRD_W         (PW),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sig       (sig),
        .ready     (ready),
        .done_tick (done_tick),
        .prd       (prd),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi_ns;
        int lo_ns;
        int exp_prd;
        bit exp_ovf;
    } vec_t;

    typedef struct {
        int prd;
        bit ovf;
    } exp_t;

    exp_t sb[$];
    int   n_run    = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   last_prd = 0;
    bit   last_ovf = 1'b0;

    // Square-wave source; starts 3 ns after a clock edge so transitions never
    // coincide with sampling edges for the periods used here.
    logic gen_en   = 1'b0;
    logic gen_busy = 1'b0;
    int   hi_ns    = 100;
    int   lo_ns    = 100;

    always begin
        if (gen_en) begin
            gen_busy = 1'b1;
            sig = 1'b1;
            #(hi_ns);
            sig = 1'b0;
            #(lo_ns);
        end else begin
            gen_busy = 1'b0;
            sig = 1'b0;
            @(posedge clk);
            #3;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_gen(input bit on, input int hi, input int lo);
        gen_en = 1'b0;
        wait (gen_busy == 1'b0);
        hi_ns  = hi;
        lo_ns  = lo;
        gen_en = on;
    endtask

    // Start that must be accepted: expectation goes onto the scoreboard.
    task automatic accept_start(input int ep, input bit eo, input string tag);
        exp_t e;
        @(negedge clk);
        chk({tag, "_ready_before"}, ready, 1);
        chk({tag, "_prd_held"}, prd, last_prd);
        chk({tag, "_ovf_held"}, ovf, last_ovf);
        e.prd = ep;
        e.ovf = eo;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_prd_cleared"}, prd, 0);
        chk({tag, "_ovf_cleared"}, ovf, 0);
        chk({tag, "_ready_busy"}, ready, 0);
        last_prd = ep;
        last_ovf = eo;
    endtask

    // Start while busy: must be ignored, so nothing is expected from it.
    task automatic stray_start(input string tag);
        @(negedge clk);
        chk({tag, "_ready_busy"}, ready, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, output int cycles);
        int n = 0;
        while (done_tick !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        cycles = n;
        chk({tag, "_done_seen"}, done_tick, 1);
        if (done_tick === 1'b1) begin
            @(negedge clk);
            chk({tag, "_ready_after"}, ready, 1);
            chk({tag, "_done_one_cycle"}, done_tick, 0);
        end else begin
            sb.delete();
        end
    endtask

    // Scoreboard consumer: every done_tick must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done_tick === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_done: got done_tick=1 expected 0");
            end else begin
                e = sb.pop_front();
                chk("done_prd", prd, e.prd);
                chk("done_ovf", ovf, e.ovf);
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: got no end of test expected finish within 900 us");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        int   cyc;
        int   d0;

        // period = hi+lo ns; tick = 40 ns; expected = floor(period/40), saturating at 255.
        tbl[0] = '{200,   200,   10,  1'b0};
        tbl[1] = '{2000,  2000,  100, 1'b0};
        tbl[2] = '{40,    40,    2,   1'b0};
        tbl[3] = '{250,   255,   12,  1'b0};  // 50.5 clocks, partial tick dropped
        tbl[4] = '{20,    20,    1,   1'b0};  // edge lands on the only wrap
        tbl[5] = '{1020,  1030,  51,  1'b0};
        tbl[6] = '{20,    10,    0,   1'b0};  // shorter than one tick
        tbl[7] = '{5100,  5100,  255, 1'b0};  // largest non-overflowing period
        tbl[8] = '{5120,  5120,  255, 1'b1};  // one tick too many
        tbl[9] = '{10000, 10000, 255, 1'b1};  // far beyond range, no wrap

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done_tick, 0);
        chk("rst_prd", prd, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            set_gen(1'b1, tbl[i].hi_ns, tbl[i].lo_ns);
            accept_start(tbl[i].exp_prd, tbl[i].exp_ovf, $sformatf("vec%0d", i));
            wait_done($sformatf("vec%0d", i), 10000, cyc);
            repeat (20) @(negedge clk);
            chk($sformatf("vec%0d_prd_hold", i), prd, tbl[i].exp_prd);
        end

        // No edge at all: timeout after TO ticks, done one cycle later.
        set_gen(1'b0, 100, 100);
        accept_start(0, 1'b1, "timeout");
        wait_done("timeout", 5000, cyc);
        chk("timeout_latency", cyc, TO * C);

        // Starts while busy are ignored: parked in WAIT_EDGE, then mid-COUNT.
        d0 = n_done;
        accept_start(100, 1'b0, "stray");
        repeat (10) @(negedge clk);
        stray_start("stray_wait");
        set_gen(1'b1, 2000, 2000);
        repeat (200) @(negedge clk);
        stray_start("stray_count");
        wait_done("stray", 5000, cyc);
        repeat (50) @(negedge clk);
        chk("stray_single_done", n_done - d0, 1);

        // Reset in the middle of COUNT: immediate reset values, no result.
        set_gen(1'b0, 100, 100);
        accept_start(100, 1'b0, "midrst");
        set_gen(1'b1, 2000, 2000);
        repeat (200) @(negedge clk);
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_done", done_tick, 0);
        chk("midrst_prd", prd, 0);
        chk("midrst_ovf", ovf, 0);
        sb.delete();
        last_prd = 0;
        last_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        chk("midrst_no_done", n_done - d0, 0);
        chk("midrst_idle", ready, 1);

        // Meter still works after the abort.
        set_gen(1'b1, 200, 200);
        accept_start(10, 1'b0, "post_rst");
        wait_done("post_rst", 2000, cyc);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
